// File: rtl/tt_um_mostparsingvex1_pkg.sv
// Shared types and constants for the tt_um_mostparsingvex1 packet parser.
// Optional build macro: PARSER_TIMEOUT_EN (mid-packet idle timeout).
package tt_um_mostparsingvex1_pkg;

    // Parser states; the encoding is visible on the status readback.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_e;

    // Readback select codes on uio_in[2:1].
    typedef enum logic [1:0] {
        SEL_LAST_SUM = 2'd0,
        SEL_GOOD_CNT = 2'd1,
        SEL_ERR_CNT  = 2'd2,
        SEL_STATUS   = 2'd3
    } rd_sel_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         MAX_LEN_DEF   = 15;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // A length byte is legal when it is 1..max_len.
    function automatic logic len_legal(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/tt_um_mostparsingvex1_if.sv
// Byte-stream bus between the pin wrapper (master) and the parser FSM (slave).
interface tt_um_mostparsingvex1_if;
    import tt_um_mostparsingvex1_pkg::*;

    logic       valid;     // byte accepted this cycle (already gated by enable)
    logic       en;        // design enable
    logic [7:0] data;
    logic       ok_evt;    // good packet decided this cycle (pre-register)
    logic       err_evt;   // bad packet decided this cycle (pre-register)
    logic       pkt_ok;
    logic       pkt_err;
    logic       busy;
    state_e     state;
    logic [3:0] cnt;
    logic [7:0] last_sum;

    modport master (
        output valid, en, data,
        input  ok_evt, err_evt, pkt_ok, pkt_err, busy, state, cnt, last_sum
    );

    modport slave (
        input  valid, en, data,
        output ok_evt, err_evt, pkt_ok, pkt_err, busy, state, cnt, last_sum
    );

endinterface

// File: rtl/tt_um_mostparsingvex1_parser_fsm.sv
// Framing FSM: SYNC, LEN, payload, XOR checksum. Owns the accumulators,
// last good payload sum and the registered ok/err pulses.
// With PARSER_TIMEOUT_EN an idle timer abandons a stalled packet.
module mostparsingvex1_parser_fsm
    import tt_um_mostparsingvex1_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_LEN   = MAX_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    tt_um_mostparsingvex1_if.slave       bus
);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [7:0] xor_q;
    logic [7:0] sum_q;
    logic [7:0] last_sum_q;
    logic       pkt_ok_q;
    logic       pkt_err_q;
    logic       ok_d;
    logic       err_d;

`ifdef PARSER_TIMEOUT_EN
    logic [7:0] timer_q;
`else
    logic unused_en;
    assign unused_en = bus.en;
`endif

    // Decide whether the current cycle ends a packet well or badly.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ok_d  = 1'b0;
        err_d = 1'b0;
        if (bus.valid) begin
            unique case (state_q)
                ST_LEN: err_d = !len_legal(bus.data, MAX_LEN);
                ST_CHK: begin
                    ok_d  = (bus.data == xor_q);
                    err_d = (bus.data != xor_q);
                end
                default: ;
            endcase
        end
`ifdef PARSER_TIMEOUT_EN
        else if (bus.en && (state_q != ST_IDLE) && (timer_q == TIMEOUT_LIMIT - 8'd1)) begin
            err_d = 1'b1;
        end
`endif
    end

    // Parser state, accumulators and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            xor_q      <= '0;
            sum_q      <= '0;
            last_sum_q <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pkt_ok_q  <= ok_d;
            pkt_err_q <= err_d;
            if (bus.valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.data == SYNC_BYTE) state_q <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (err_d) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= bus.data[3:0];
                            xor_q   <= '0;
                            sum_q   <= '0;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        xor_q <= xor_q ^ bus.data;
                        sum_q <= sum_q + bus.data;
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_q <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (ok_d) last_sum_q <= sum_q;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
`ifdef PARSER_TIMEOUT_EN
            // Idle timer: only runs mid-packet while enabled and starved of bytes.
            if (bus.valid || (state_q == ST_IDLE)) begin
                timer_q <= '0;
            end else if (bus.en) begin
                if (err_d) begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + 8'd1;
                end
            end
`endif
        end
    end

    assign bus.ok_evt   = ok_d;
    assign bus.err_evt  = err_d;
    assign bus.pkt_ok   = pkt_ok_q;
    assign bus.pkt_err  = pkt_err_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.state    = state_q;
    assign bus.cnt      = cnt_q;
    assign bus.last_sum = last_sum_q;

endmodule

// File: rtl/tt_um_mostparsingvex1.sv
// Tiny Tapeout wrapper for the byte-stream packet parser: pin mapping,
// good/error packet counters and the readback mux.
// Optional build macro: PARSER_TIMEOUT_EN (passed through to the parser FSM).
module tt_um_mostparsingvex1
    import tt_um_mostparsingvex1_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_LEN   = MAX_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tt_um_mostparsingvex1_if bus ();

    logic [7:0] good_cnt_q;
    logic [7:0] err_cnt_q;

    // Upper uio_in bits carry nothing.
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};

    assign bus.en    = ena;
    assign bus.valid = ena & uio_in[0];
    assign bus.data  = ui_in;

    mostparsingvex1_parser_fsm #(
        .SYNC_BYTE (SYNC_BYTE),
        .MAX_LEN   (MAX_LEN)
    ) u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Packet counters advance on the same edge that decides the packet; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (bus.ok_evt)  good_cnt_q <= good_cnt_q + 8'd1;
            if (bus.err_evt) err_cnt_q  <= err_cnt_q + 8'd1;
        end
    end

    // Readback mux, combinational from registers.
    always_comb begin
        uo_out = '0;
        unique case (rd_sel_e'(uio_in[2:1]))
            SEL_LAST_SUM: uo_out = bus.last_sum;
            SEL_GOOD_CNT: uo_out = good_cnt_q;
            SEL_ERR_CNT:  uo_out = err_cnt_q;
            SEL_STATUS:   uo_out = {2'b00, bus.state, bus.cnt};
            default:      uo_out = '0;
        endcase
    end

    assign uio_out = {1'b0, bus.busy, bus.pkt_err, bus.pkt_ok, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_mostparsingvex1.sv
// Self-checking bench for tt_um_mostparsingvex1. Expected ok/err pulses are
// queued when the deciding byte is driven and popped by a negedge monitor;
// readback values are checked inline per scenario.
module tb_tt_um_mostparsingvex1;

    logic       clk;
    logic       rst_n;
    logic [1:0] sel;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_mostparsingvex1_if bus ();

    tt_um_mostparsingvex1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus.en),
        .ui_in   (bus.data),
        .uo_out  (uo_out),
        .uio_in  ({5'b00000, sel, bus.valid}),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] EV_OK  = 2'b01;
    localparam logic [1:0] EV_ERR = 2'b10;

    logic [1:0] exp_q[$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic       mon_en    = 1'b0;

    logic [7:0] exp_good = 8'd0;
    logic [7:0] exp_err  = 8'd0;
    logic [7:0] exp_sum  = 8'd0;

    wire pkt_ok  = uio_out[4];
    wire pkt_err = uio_out[5];
    wire busy    = uio_out[6];

    // Pulse monitor: every pulse cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en && (pkt_ok || pkt_err)) begin
            logic [1:0] got;
            logic [1:0] want;
            got = {pkt_err, pkt_ok};
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL pulse_unexpected: got ok/err=%b want none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL pulse: got ok/err=%b want %b", got, want);
                else pass_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [1:0] ev = 2'b00);
        if (ev != 2'b00) exp_q.push_back(ev);
        bus.en    = 1'b1;
        bus.data  = b;
        bus.valid = 1'b1;
        @(negedge clk);
        bus.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] s, output logic [7:0] v);
        sel = s;
        #1;
        v = uo_out;
    endtask

    task automatic expect_rd(input string name, input logic [1:0] s, input logic [7:0] want);
        logic [7:0] v;
        rd(s, v);
        total_cnt++;
        if (v !== want) $display("FAIL %s: got %02h want %02h", name, v, want);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_rd("rst_last_sum", 2'd0, 8'h00);
        expect_rd("rst_good_cnt", 2'd1, 8'h00);
        expect_rd("rst_err_cnt",  2'd2, 8'h00);
        expect_rd("rst_status",   2'd3, 8'h00);
        total_cnt++;
        if (uio_out !== 8'h00) $display("FAIL rst_uio_out: got %02h want 00", uio_out);
        else pass_cnt++;
        total_cnt++;
        if (uio_oe !== 8'hF0) $display("FAIL uio_oe: got %02h want f0", uio_oe);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_good_packet();
        send(8'hA5); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
        send(8'h00, EV_OK);
        exp_good++; exp_sum = 8'h06;
        idle(2);
        expect_rd("good_last_sum", 2'd0, exp_sum);
        expect_rd("good_good_cnt", 2'd1, exp_good);
        expect_rd("good_err_cnt",  2'd2, exp_err);
    endtask

    task automatic test_bad_checksum();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20);
        send(8'hFF, EV_ERR);
        exp_err++;
        idle(2);
        expect_rd("badchk_err_cnt",  2'd2, exp_err);
        expect_rd("badchk_last_sum", 2'd0, exp_sum);
        expect_rd("badchk_status",   2'd3, 8'h00);
    endtask

    task automatic test_framing();
        send(8'h00); send(8'hFF); send(8'h5A);
        expect_rd("garbage_status", 2'd3, 8'h00);
        send(8'hA5); send(8'h00, EV_ERR);
        exp_err++;
        send(8'hA5); send(8'h10, EV_ERR);
        exp_err++;
        idle(2);
        expect_rd("framing_err_cnt", 2'd2, exp_err);
        expect_rd("framing_good_cnt", 2'd1, exp_good);
    endtask

    task automatic test_gaps_enable();
        send(8'hA5); send(8'h01);
        idle(5);
        bus.en = 1'b0; bus.valid = 1'b1; bus.data = 8'h55;
        repeat (3) @(negedge clk);
        expect_rd("ena_low_status", 2'd3, 8'h21);
        bus.valid = 1'b0; bus.en = 1'b1;
        send(8'h7F); send(8'h7F, EV_OK);
        exp_good++; exp_sum = 8'h7F;
        idle(2);
        expect_rd("gaps_last_sum", 2'd0, exp_sum);
        expect_rd("gaps_good_cnt", 2'd1, exp_good);
    endtask

    task automatic test_max_len();
        send(8'hA5); send(8'h0F);
        for (int i = 0; i < 15; i++) send(8'h01);
        send(8'h01, EV_OK);
        exp_good++; exp_sum = 8'h0F;
        idle(2);
        expect_rd("maxlen_last_sum", 2'd0, exp_sum);
        expect_rd("maxlen_good_cnt", 2'd1, exp_good);
    endtask

    task automatic test_err_wrap();
        for (int i = 0; i < 256; i++) begin
            send(8'hA5); send(8'h00, EV_ERR);
        end
        idle(2);
        expect_rd("err_cnt_wrap", 2'd2, exp_err);
    endtask

    task automatic test_reset_mid_packet();
        send(8'hA5); send(8'h04); send(8'h11);
        expect_rd("mid_status", 2'd3, 8'h23);
        rst_n = 1'b0;
        #2;
        expect_rd("midrst_last_sum", 2'd0, 8'h00);
        expect_rd("midrst_good_cnt", 2'd1, 8'h00);
        expect_rd("midrst_err_cnt",  2'd2, 8'h00);
        expect_rd("midrst_status",   2'd3, 8'h00);
        total_cnt++;
        if (uio_out !== 8'h00) $display("FAIL midrst_uio_out: got %02h want 00", uio_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_good = 8'd0; exp_err = 8'd0;
        send(8'hA5); send(8'h01); send(8'h22); send(8'h22, EV_OK);
        exp_good++; exp_sum = 8'h22;
        idle(2);
        expect_rd("post_rst_good_cnt", 2'd1, exp_good);
        expect_rd("post_rst_last_sum", 2'd0, exp_sum);
    endtask

    task automatic test_timeout();
        int n;
        send(8'hA5); send(8'h02); send(8'h33);
`ifdef PARSER_TIMEOUT_EN
        exp_q.push_back(EV_ERR);
        exp_err++;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (n != 255) $display("FAIL timeout_cycles: got %0d want 255", n);
        else pass_cnt++;
        idle(2);
        expect_rd("timeout_err_cnt", 2'd2, exp_err);
`else
        n = 0;
        idle(300);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL no_timeout_busy: got %b want 1", busy);
        else pass_cnt++;
        send(8'h44); send(8'h77, EV_OK);
        exp_good++; exp_sum = 8'h77;
        idle(2);
        expect_rd("no_timeout_last_sum", 2'd0, exp_sum);
`endif
        expect_rd("timeout_status", 2'd3, 8'h00);
    endtask

    initial begin
        bus.en    = 1'b1;
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        sel       = 2'd0;
        rst_n     = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_framing();
        test_gaps_enable();
        test_max_len();
        test_err_wrap();
        test_reset_mid_packet();
        test_timeout();
        idle(3);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL missing_pulses: got %0d pending want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tt_um_mostparsingvex1.md
Name: tt_um_mostparsingvex1

Overview:
Tiny Tapeout user block implementing a byte-stream packet parser. It validates framed packets of the form SYNC, LEN, LEN payload bytes and an XOR checksum. It reports per-packet ok/error pulses, latches the 8-bit payload sum of the last good packet, and keeps good and error counters. All data enters on ui_in, qualified by a valid strobe on uio_in.

Parameters:
SYNC_BYTE, 8'hA5, header byte that starts a packet.
MAX_LEN, 15, largest legal payload length (1..15; fits in a 4-bit counter).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  design enable; when low, in_valid is ignored and all state holds.
ui_in  in  8  data byte.
uo_out  out  8  readback bus selected by uio_in[2:1].
uio_in  in  8  [0]=in_valid, [2:1]=readback select, [7:3] unused.
uio_out  out  8  [4]=pkt_ok, [5]=pkt_err, [6]=busy, [7]=0, [3:0]=0.
uio_oe  out  8  constant 8'hF0.

Behaviour:
- Reset is asynchronous and active-low on rst_n. Reset clears state to IDLE and zeroes cnt, xor_acc, sum_acc, last_sum, good_cnt, err_cnt, pkt_ok and pkt_err. After reset, uo_out=0 and uio_out=0.
- A byte is accepted on a rising clk edge when ena=1 and uio_in[0]=1. Each high cycle accepts one byte; there is no backpressure.
- FSM states and encodings: IDLE=0, LEN=1, PAYLOAD=2, CHK=3.
- IDLE: an accepted byte equal to SYNC_BYTE moves to LEN. Any other byte is silently dropped.
- LEN: an accepted byte of 0 or greater than MAX_LEN causes pkt_err and a return to IDLE. Otherwise cnt is loaded with the byte, xor_acc and sum_acc are cleared, and the FSM moves to PAYLOAD.
- PAYLOAD: each accepted byte updates xor_acc^=b, sum_acc+=b (mod 256) and cnt-=1. When cnt==1 before the decrement, the FSM moves to CHK.
- CHK, accepted byte equals xor_acc: pkt_ok pulses, last_sum is loaded with sum_acc, good_cnt increments.
- CHK, accepted byte differs from xor_acc: pkt_err pulses and err_cnt increments.
- CHK always returns to IDLE after its byte.
- pkt_ok and pkt_err are registered, high for exactly one cycle following the edge that accepted the deciding byte. They are never high together.
- A SYNC_BYTE value received in LEN, PAYLOAD or CHK is treated as ordinary data; there is no resync.
- good_cnt and err_cnt are 8 bits and wrap 255 to 0.
- busy = (state != IDLE), combinational from the state register.
- uo_out is combinational from registers, selected by uio_in[2:1]:
  - 00 = last_sum
  - 01 = good_cnt
  - 10 = err_cnt
  - 11 = {2'b00, state[1:0], cnt[3:0]}
- Reset mid-packet aborts the packet with no pulse; counters return to 0.

Optional Feature:
Macro PARSER_TIMEOUT_EN.
- Defined: an 8-bit idle timer counts clocks while busy and no byte is accepted. It clears on every accepted byte and on entry to IDLE. When the timer reaches 255, the packet is abandoned: pkt_err pulses, err_cnt increments, state goes to IDLE.
- Undefined: no timer; the parser waits indefinitely mid-packet.

Decomposition:
- Package tt_um_mostparsingvex1_pkg holds the state enum (IDLE/LEN/PAYLOAD/CHK), readback select codes, SYNC_BYTE and MAX_LEN defaults, and the timeout limit 8'd255.
- One sub-module, mostparsingvex1_parser_fsm, contains the FSM, accumulators and pulses.
- The top level holds the counters, the readback mux and the pin mapping.

Test Plan:
- Good packet: send A5 03 01 02 03 00 -> one-cycle pkt_ok; select 00 reads 06; select 01 reads 01; err_cnt stays 0.
- Bad checksum: send A5 02 10 20 FF -> one-cycle pkt_err; err_cnt=1; last_sum unchanged; select 11 shows state 0.
- Framing: garbage 00 FF 5A, then A5 00 -> garbage ignored with no pulse; LEN=0 gives pkt_err. Then A5 10 (16 > MAX_LEN) -> pkt_err; err_cnt=2.
- Gaps and enable: valid low for 5 cycles between payload bytes, and ena low while valid high -> those bytes are ignored; packet A5 01 7F 7F completes with pkt_ok and last_sum=7F.
- Reset mid-packet: assert rst_n low after A5 04 11 -> all outputs 0, state IDLE. A following good packet A5 01 22 22 gives good_cnt=1.
- PARSER_TIMEOUT_EN: send A5 02 33, then hold valid low for 255 cycles -> pkt_err, busy drops. Without the macro, busy stays high.
